// File: rtl/rc_pulse_capture.sv
// Multi-channel RC pulse-width capture: sync, deglitch, measure high/low widths per channel.
// Latency: capture/valid update SYNC_STAGES+FILTER_LEN+1 edges after the input change is sampled.
// Backpressure: none; an unacknowledged capture is overwritten and flagged as overrun.
module rc_pulse_capture #(
    parameter int NUM_CH      = 8,
    parameter int CNT_W       = 31,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT     = 2500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       pulse_in,
    input  logic [NUM_CH-1:0]       ack,
    output logic [NUM_CH-1:0]       level,
    output logic [NUM_CH*CNT_W-1:0] high_width,
    output logic [NUM_CH*CNT_W-1:0] low_width,
    output logic [NUM_CH-1:0]       high_valid,
    output logic [NUM_CH-1:0]       low_valid,
    output logic [NUM_CH-1:0]       overrun,
    output logic [NUM_CH-1:0]       timeout
);

    // Filter counter only needs to reach FILTER_LEN-1.
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_ff;
        logic                   sync_lvl;
        logic [FCW-1:0]         filt_cnt;
        logic                   level_r;
        logic                   level_d;
        logic                   filt_edge;
        logic                   armed;
        logic [CNT_W-1:0]       tick;
        logic [CNT_W-1:0]       width_new;
        logic                   cap_high;
        logic                   cap_low;
        logic [CNT_W-1:0]       hw_r;
        logic [CNT_W-1:0]       lw_r;
        logic                   hv_r;
        logic                   lv_r;
        logic                   ov_r;
        logic                   to_r;

        assign sync_lvl  = sync_ff[SYNC_STAGES-1];
        // The edge is seen one cycle after level moves, so both polarities see the same delay.
        assign filt_edge = level_r ^ level_d;
        // Tick holds cycles-since-edge minus one; add one, but never wrap past all-ones.
        assign width_new = (&tick) ? tick : tick + CNT_W'(1);
        // level_r already holds the new level: low means the high half just ended.
        assign cap_high  = filt_edge & armed & ~level_r;
        assign cap_low   = filt_edge & armed & level_r;

        // Metastability chain on the asynchronous pin.
        always_ff @(posedge clk) begin
            if (reset) sync_ff <= '0;
            else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], pulse_in[i]};
        end

        // Accept a level change only after FILTER_LEN consecutive disagreeing samples.
        always_ff @(posedge clk) begin
            if (reset) begin
                filt_cnt <= '0;
                level_r  <= 1'b0;
            end else if (sync_lvl != level_r) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    level_r  <= ~level_r;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FCW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end

        // Delayed level for edge detection, and arming on the first edge after reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                level_d <= 1'b0;
                armed   <= 1'b0;
            end else begin
                level_d <= level_r;
                if (filt_edge) armed <= 1'b1;
            end
        end

        // Cycles since the last filtered edge (or reset), saturating.
        always_ff @(posedge clk) begin
            if (reset)          tick <= '0;
            else if (filt_edge) tick <= '0;
            else if (!(&tick))  tick <= tick + CNT_W'(1);
        end

        // Capture registers with valid handshake; a capture beats a same-cycle ack.
        always_ff @(posedge clk) begin
            if (reset) begin
                hw_r <= '0;
                lw_r <= '0;
                hv_r <= 1'b0;
                lv_r <= 1'b0;
            end else begin
                if (cap_high) begin
                    hw_r <= width_new;
                    hv_r <= 1'b1;
                end else if (ack[i]) begin
                    hv_r <= 1'b0;
                end
                if (cap_low) begin
                    lw_r <= width_new;
                    lv_r <= 1'b1;
                end else if (ack[i]) begin
                    lv_r <= 1'b0;
                end
            end
        end

        // Overrun: a capture landed on a still-valid, unacknowledged half; sticky until ack.
        always_ff @(posedge clk) begin
            if (reset) begin
                ov_r <= 1'b0;
            end else if (((cap_high & hv_r) | (cap_low & lv_r)) & ~ack[i]) begin
                ov_r <= 1'b1;
            end else if (ack[i]) begin
                ov_r <= 1'b0;
            end
        end

        // Signal-loss flag: raised once tick hits TIMEOUT, dropped by the next filtered edge.
        always_ff @(posedge clk) begin
            if (reset)                          to_r <= 1'b0;
            else if (filt_edge)                 to_r <= 1'b0;
            else if (tick == CNT_W'(TIMEOUT))   to_r <= 1'b1;
        end

        assign level[i]                     = level_r;
        assign high_width[i*CNT_W +: CNT_W] = hw_r;
        assign low_width[i*CNT_W +: CNT_W]  = lw_r;
        assign high_valid[i]                = hv_r;
        assign low_valid[i]                 = lv_r;
        assign overrun[i]                   = ov_r;
        assign timeout[i]                   = to_r;
    end

endmodule
